// File: rtl/mux_arb2_pkg.sv
// Shared types and constants for the two-input arbitrating mux.
package mux_arb2_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/mux_arb2_mux.sv
// 1-bit 2:1 multiplexer; selects i1 when s is high.
module mux_arb2_mux (
    output logic Y,
    input  logic i0,
    input  logic i1,
    input  logic s
);

    assign Y = s ? i1 : i0;

endmodule

// File: rtl/mux_arb2.sv
// Two-requester round-robin arbiter feeding a one-entry registered output stream.
// Optional per-requester transfer counters are enabled by defining MUX_ARB2_STATS_EN.
module mux_arb2
    import mux_arb2_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic             i0_valid,
    output logic             i0_ready,
    input  logic [WIDTH-1:0] i1,
    input  logic             i1_valid,
    output logic             i1_ready,
    output logic             s,
`ifdef MUX_ARB2_STATS_EN
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
`endif
    output logic [WIDTH-1:0] Y,
    output logic             y_valid,
    input  logic             y_ready
);

    out_state_e       r_state;
    logic             r_prio;
    logic [WIDTH-1:0] r_y;

    logic             w_can_load;
    logic             w_xfer0;
    logic             w_xfer1;
    logic             w_xfer;
    logic [WIDTH-1:0] w_mux_y;

    // Ready is held low during reset so nothing is accepted on a reset edge.
    assign w_can_load = !rst && ((r_state == EMPTY) || y_ready);

    always_comb begin
        s = r_prio;
        unique case ({i1_valid, i0_valid})
            2'b01:   s = 1'b0;
            2'b10:   s = 1'b1;
            default: s = r_prio;
        endcase
    end

    assign i0_ready = w_can_load && !s;
    assign i1_ready = w_can_load && s;
    assign w_xfer0  = i0_valid && i0_ready;
    assign w_xfer1  = i1_valid && i1_ready;
    assign w_xfer   = w_xfer0 || w_xfer1;

    for (genvar g = 0; g < WIDTH; g++) begin : g_mux
        mux_arb2_mux u_mux (
            .Y  (w_mux_y[g]),
            .i0 (i0[g]),
            .i1 (i1[g]),
            .s  (s)
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_y     <= '0;
            r_prio  <= 1'b0;
        end else if (w_xfer) begin
            r_state <= FULL;
            r_y     <= w_mux_y;
            r_prio  <= ~s;
        end else if (y_ready) begin
            r_state <= EMPTY;
        end
    end

    assign Y       = r_y;
    assign y_valid = (r_state == FULL);

`ifdef MUX_ARB2_STATS_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_xfer0 && (r_cnt0 != {CNT_W{1'b1}})) begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
            if (w_xfer1 && (r_cnt1 != {CNT_W{1'b1}})) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_mux_arb2.sv
// Directed self-checking bench for mux_arb2; counter checks run when MUX_ARB2_STATS_EN is defined.
module tb_mux_arb2;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] i0;
    logic             i0_valid;
    logic             i0_ready;
    logic [WIDTH-1:0] i1;
    logic             i1_valid;
    logic             i1_ready;
    logic             s;
    logic [WIDTH-1:0] Y;
    logic             y_valid;
    logic             y_ready;
`ifdef MUX_ARB2_STATS_EN
    logic [15:0]      cnt0;
    logic [15:0]      cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_arb2 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .i0       (i0),
        .i0_valid (i0_valid),
        .i0_ready (i0_ready),
        .i1       (i1),
        .i1_valid (i1_valid),
        .i1_ready (i1_ready),
        .s        (s),
`ifdef MUX_ARB2_STATS_EN
        .cnt0     (cnt0),
        .cnt1     (cnt1),
`endif
        .Y        (Y),
        .y_valid  (y_valid),
        .y_ready  (y_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] fair_exp [4];

    initial begin
        fair_exp[0] = 8'h11;
        fair_exp[1] = 8'h22;
        fair_exp[2] = 8'h11;
        fair_exp[3] = 8'h22;

        // Reset held for two edges with both requesters valid.
        rst = 1'b1; i0 = 8'hAA; i1 = 8'hBB; i0_valid = 1'b1; i1_valid = 1'b1; y_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("rst_y_valid", 32'(y_valid), 32'h0);
            check("rst_Y", 32'(Y), 32'h0);
            check("rst_i0_ready", 32'(i0_ready), 32'h0);
            check("rst_i1_ready", 32'(i1_ready), 32'h0);
        end
        rst = 1'b0; i0_valid = 1'b0; i1_valid = 1'b0;
        #1;
        check("post_rst_s", 32'(s), 32'h0);
`ifdef MUX_ARB2_STATS_EN
        check("post_rst_cnt0", 32'(cnt0), 32'h0);
`endif

        // Single requester 0.
        i0 = 8'hA5; i0_valid = 1'b1;
        #1;
        check("single_s", 32'(s), 32'h0);
        check("single_i0_ready", 32'(i0_ready), 32'h1);
        check("single_i1_ready", 32'(i1_ready), 32'h0);
        tick();
        i0_valid = 1'b0;
        #1;
        check("single_Y", 32'(Y), 32'hA5);
        check("single_y_valid", 32'(y_valid), 32'h1);
        check("single_prio_s", 32'(s), 32'h1);

        // Drain with no input; data changes with valid low are ignored.
        i0 = 8'hFF;
        tick();
        check("drain_y_valid", 32'(y_valid), 32'h0);
        check("drain_Y_hold", 32'(Y), 32'hA5);

        // Short reset to restore prio=0, then fairness.
        rst = 1'b1;
        tick();
        rst = 1'b0; i0 = 8'h11; i1 = 8'h22; i0_valid = 1'b1; i1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("fair_one_ready", 32'(i0_ready & i1_ready), 32'h0);
            tick();
            check("fair_Y", 32'(Y), 32'(fair_exp[k]));
            check("fair_y_valid", 32'(y_valid), 32'h1);
        end

        // Load 3C, then apply backpressure.
        i0 = 8'h3C; i1_valid = 1'b0;
        tick();
        check("bp_load_Y", 32'(Y), 32'h3C);
        y_ready = 1'b0; i0 = 8'h44; i1 = 8'h55; i1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_i0_ready", 32'(i0_ready), 32'h0);
            check("bp_i1_ready", 32'(i1_ready), 32'h0);
            tick();
            check("bp_Y", 32'(Y), 32'h3C);
            check("bp_y_valid", 32'(y_valid), 32'h1);
        end
        y_ready = 1'b1;
        #1;
        check("bp_release_s", 32'(s), 32'h1);
        check("bp_release_i1_ready", 32'(i1_ready), 32'h1);
        tick();
        check("bp_release_Y", 32'(Y), 32'h55);
        check("bp_release_y_valid", 32'(y_valid), 32'h1);

        // Reset while FULL holding 77.
        i0 = 8'h77; i1_valid = 1'b0; i0_valid = 1'b1;
        tick();
        check("mid_load_Y", 32'(Y), 32'h77);
        i0_valid = 1'b0; y_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_y_valid", 32'(y_valid), 32'h0);
        check("mid_rst_Y", 32'(Y), 32'h0);
        y_ready = 1'b1;
        tick();
        check("mid_after_y_valid", 32'(y_valid), 32'h0);
        check("mid_after_Y", 32'(Y), 32'h0);

`ifdef MUX_ARB2_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0; i0 = 8'h01; i0_valid = 1'b1; i1_valid = 1'b0; y_ready = 1'b1;
        for (int k = 0; k < 70000; k++) begin
            tick();
        end
        i0_valid = 1'b0;
        check("stats_cnt0", 32'(cnt0), 32'hFFFF);
        check("stats_cnt1", 32'(cnt1), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
